// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF (read-only) and MEM (read/write), fixed MEM priority with IF starvation guard
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_Address,
    input  logic        if_MemRead,
    output logic        if_Req_Ready,
    output logic        if_Read_data_Valid,
    input  logic        if_Read_data_Ready,
    input  logic [31:0] mem_Address,
    input  logic        mem_MemRead,
    input  logic        mem_MemWrite,
    input  logic [31:0] mem_Write_data,
    input  logic [3:0]  mem_Write_strb,
    output logic        mem_Req_Ready,
    output logic        mem_Read_data_Valid,
    input  logic        mem_Read_data_Ready,
    output logic [31:0] Read_data_out,
    output logic [31:0] Address,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Write_data,
    output logic [3:0]  Write_strb,
    input  logic        Mem_Req_Ready,
    input  logic [31:0] Read_data,
    input  logic        Read_data_Valid,
    output logic        Read_data_Ready,
    output logic        grant_if,
    output logic        grant_mem
);
    localparam logic [2:0] IDLE = 3'b001, GNT = 3'b010, RESP = 3'b100;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    logic [2:0] state, state_nx;
    logic [CNT_W-1:0] starve_cnt, starve_nx;
    logic gnt_if_nx, gnt_mem_nx;
    logic in_gnt, in_resp, mem_req, starve_hit, win_req, win_read, accept, resp_done;
    assign in_gnt     = state == GNT;
    assign in_resp    = state == RESP;
    assign mem_req    = mem_MemRead | mem_MemWrite;
    assign starve_hit = (STARVE_LIMIT != 0) && if_MemRead && (starve_cnt == LIMIT);
    assign win_req    = grant_mem ? mem_req : if_MemRead;
    assign win_read   = grant_mem ? mem_MemRead : 1'b1;
    assign accept     = in_gnt & win_req & Mem_Req_Ready;
    assign resp_done  = in_resp & Read_data_Valid & Read_data_Ready;
    assign Read_data_out = Read_data;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant_if   <= 1'b0;
            grant_mem  <= 1'b0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nx;
            grant_if   <= gnt_if_nx;
            grant_mem  <= gnt_mem_nx;
            starve_cnt <= starve_nx;
        end
    end
    always_comb begin
        state_nx   = state;
        gnt_if_nx  = grant_if;
        gnt_mem_nx = grant_mem;
        starve_nx  = starve_cnt;
        case (state)
            IDLE: begin
                gnt_mem_nx = mem_req & ~starve_hit;
                gnt_if_nx  = ~gnt_mem_nx & if_MemRead;
                state_nx   = (gnt_mem_nx | gnt_if_nx) ? GNT : IDLE;
            end
            GNT: begin
                state_nx = !win_req ? IDLE : !Mem_Req_Ready ? GNT : win_read ? RESP : IDLE;
                // a waiting IF only counts against MEM grants it actually sat through
                if (accept)
                    starve_nx = (grant_if || !if_MemRead) ? '0 :
                                (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 1'b1;
            end
            RESP:    state_nx = resp_done ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
        if (state_nx == IDLE) begin
            gnt_if_nx  = 1'b0;
            gnt_mem_nx = 1'b0;
        end
    end
    always_comb begin
        Address             = in_gnt ? (grant_mem ? mem_Address : if_Address) : '0;
        MemRead             = in_gnt & (grant_mem ? mem_MemRead : if_MemRead);
        MemWrite            = in_gnt & grant_mem & mem_MemWrite;
        Write_data          = (in_gnt & grant_mem) ? mem_Write_data : '0;
        Write_strb          = (in_gnt & grant_mem) ? mem_Write_strb : '0;
        if_Req_Ready        = in_gnt & grant_if & if_MemRead & Mem_Req_Ready;
        mem_Req_Ready       = in_gnt & grant_mem & mem_req & Mem_Req_Ready;
        Read_data_Ready     = in_resp & (grant_mem ? mem_Read_data_Ready : if_Read_data_Ready);
        if_Read_data_Valid  = in_resp & grant_if & Read_data_Valid;
        mem_Read_data_Valid = in_resp & grant_mem & Read_data_Valid;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, starvation guard, response routing and reset abort
module tb_mem_port_arbiter;
    logic        clk = 1'b0, rst = 1'b0;
    logic [31:0] if_Address = '0, mem_Address = '0, mem_Write_data = '0, Read_data = '0;
    logic        if_MemRead = 1'b0, if_Read_data_Ready = 1'b0;
    logic        mem_MemRead = 1'b0, mem_MemWrite = 1'b0, mem_Read_data_Ready = 1'b0;
    logic [3:0]  mem_Write_strb = '0;
    logic        Mem_Req_Ready = 1'b0, Read_data_Valid = 1'b0;
    logic        if_Req_Ready, if_Read_data_Valid, mem_Req_Ready, mem_Read_data_Valid;
    logic [31:0] Read_data_out, Address, Write_data;
    logic        MemRead, MemWrite, Read_data_Ready, grant_if, grant_mem;
    logic [3:0]  Write_strb;
    int checks = 0, errors = 0;
    int n_mem;
    logic if_seen;

    mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .if_Address(if_Address), .if_MemRead(if_MemRead), .if_Req_Ready(if_Req_Ready),
        .if_Read_data_Valid(if_Read_data_Valid), .if_Read_data_Ready(if_Read_data_Ready),
        .mem_Address(mem_Address), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .mem_Write_data(mem_Write_data), .mem_Write_strb(mem_Write_strb), .mem_Req_Ready(mem_Req_Ready),
        .mem_Read_data_Valid(mem_Read_data_Valid), .mem_Read_data_Ready(mem_Read_data_Ready),
        .Read_data_out(Read_data_out), .Address(Address), .MemRead(MemRead), .MemWrite(MemWrite),
        .Write_data(Write_data), .Write_strb(Write_strb), .Mem_Req_Ready(Mem_Req_Ready),
        .Read_data(Read_data), .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready),
        .grant_if(grant_if), .grant_mem(grant_mem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Read_data = 32'hA5A5_A5A5;
        if_Read_data_Ready = 1'b1;
        #3;
        chk("rst_grant_if", 32'(grant_if), 0);
        chk("rst_grant_mem", 32'(grant_mem), 0);
        chk("rst_memread", 32'(MemRead), 0);
        chk("rst_address", Address, 0);
        chk("rst_rd_ready", 32'(Read_data_Ready), 0);
        chk("rst_passthru", Read_data_out, 32'hA5A5_A5A5);
        if_Read_data_Ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // 1) lone IF read, memory accepts after 2 cycles
        if_Address = 32'h0000_1000; if_MemRead = 1'b1;
        tick();
        chk("t1_grant_if", 32'(grant_if), 1);
        chk("t1_memread", 32'(MemRead), 1);
        chk("t1_addr", Address, 32'h0000_1000);
        chk("t1_req_ready_wait", 32'(if_Req_Ready), 0);
        tick();
        chk("t1_held_gnt", 32'(MemRead), 1);
        Mem_Req_Ready = 1'b1;
        #1 chk("t1_req_ready", 32'(if_Req_Ready), 1);
        tick();
        if_MemRead = 1'b0; Mem_Req_Ready = 1'b0;
        #1 chk("t1_resp_memread", 32'(MemRead), 0);
        Read_data = 32'hDEAD_BEEF; Read_data_Valid = 1'b1; if_Read_data_Ready = 1'b1;
        #1;
        chk("t1_if_valid", 32'(if_Read_data_Valid), 1);
        chk("t1_mem_valid", 32'(mem_Read_data_Valid), 0);
        chk("t1_data", Read_data_out, 32'hDEAD_BEEF);
        chk("t1_rd_ready", 32'(Read_data_Ready), 1);
        tick();
        Read_data_Valid = 1'b0; if_Read_data_Ready = 1'b0;
        chk("t1_idle", 32'(grant_if), 0);

        // 2) simultaneous IF read and MEM write: MEM first
        if_Address = 32'h0000_3000; if_MemRead = 1'b1;
        mem_Address = 32'h0000_2004; mem_MemWrite = 1'b1;
        mem_Write_data = 32'h1234_5678; mem_Write_strb = 4'b0011; Mem_Req_Ready = 1'b1;
        tick();
        chk("t2_grant_mem", 32'(grant_mem), 1);
        chk("t2_memwrite", 32'(MemWrite), 1);
        chk("t2_strb", 32'(Write_strb), 32'h3);
        chk("t2_addr", Address, 32'h0000_2004);
        chk("t2_wdata", Write_data, 32'h1234_5678);
        chk("t2_if_not_ready", 32'(if_Req_Ready), 0);
        tick();
        mem_MemWrite = 1'b0;
        chk("t2_idle_after_write", 32'(grant_mem), 0);
        tick();
        chk("t2_grant_if", 32'(grant_if), 1);
        chk("t2_if_addr", Address, 32'h0000_3000);
        chk("t2_if_nowrite", 32'(MemWrite), 0);
        tick();
        if_MemRead = 1'b0; Read_data_Valid = 1'b1; if_Read_data_Ready = 1'b1;
        tick();
        Read_data_Valid = 1'b0; if_Read_data_Ready = 1'b0;

        // 3) continuous MEM writes starve IF until the guard forces it
        if_MemRead = 1'b1; mem_MemWrite = 1'b1; Mem_Req_Ready = 1'b1;
        n_mem = 0; if_seen = 1'b0;
        for (int i = 0; i < 40 && !if_seen; i++) begin
            tick();
            if (mem_Req_Ready) n_mem++;
            if (if_Req_Ready) if_seen = 1'b1;
        end
        chk("t3_if_granted", 32'(if_seen), 1);
        chk("t3_mem_writes", n_mem, 4);
        chk("t3_cnt_sat", 32'(dut.starve_cnt), 4);
        mem_MemWrite = 1'b0;
        tick();
        chk("t3_cnt_clear", 32'(dut.starve_cnt), 0);
        chk("t3_resp_if", 32'(grant_if), 1);
        if_MemRead = 1'b0; Read_data_Valid = 1'b1; if_Read_data_Ready = 1'b1;
        tick();
        Read_data_Valid = 1'b0; if_Read_data_Ready = 1'b0;

        // 4) MEM read, response held while requester not ready
        mem_Address = 32'h0000_4000; mem_MemRead = 1'b1; Mem_Req_Ready = 1'b1;
        tick();
        chk("t4_memread", 32'(MemRead), 1);
        tick();
        mem_MemRead = 1'b0; Mem_Req_Ready = 1'b0;
        Read_data = 32'hCAFE_F00D; Read_data_Valid = 1'b1; if_Read_data_Ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_mem_valid", 32'(mem_Read_data_Valid), 1);
            chk("t4_rd_ready_low", 32'(Read_data_Ready), 0);
            chk("t4_if_valid", 32'(if_Read_data_Valid), 0);
            tick();
        end
        chk("t4_still_resp", 32'(grant_mem), 1);
        mem_Read_data_Ready = 1'b1;
        #1 chk("t4_rd_ready", 32'(Read_data_Ready), 1);
        tick();
        chk("t4_done", 32'(grant_mem), 0);
        Read_data_Valid = 1'b0; mem_Read_data_Ready = 1'b0; if_Read_data_Ready = 1'b0;

        // 5) async reset while in RESP, then a stray response
        if_MemRead = 1'b1; Mem_Req_Ready = 1'b1;
        tick();
        tick();
        if_MemRead = 1'b0; Mem_Req_Ready = 1'b0; Read_data_Valid = 1'b1; if_Read_data_Ready = 1'b1;
        #1 chk("t5_pre_valid", 32'(if_Read_data_Valid), 1);
        #1 rst = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(if_Read_data_Valid), 0);
        chk("t5_rst_rd_ready", 32'(Read_data_Ready), 0);
        chk("t5_rst_grant", 32'(grant_if), 0);
        tick();
        rst = 1'b1;
        tick();
        chk("t5_stray_if", 32'(if_Read_data_Valid), 0);
        chk("t5_stray_mem", 32'(mem_Read_data_Valid), 0);
        chk("t5_stray_ready", 32'(Read_data_Ready), 0);
        Read_data_Valid = 1'b0; if_Read_data_Ready = 1'b0;

        // 6) winner drops its request while waiting in GNT
        mem_Address = 32'h0000_5000; mem_MemWrite = 1'b1;
        tick();
        chk("t6_memwrite", 32'(MemWrite), 1);
        mem_MemWrite = 1'b0;
        #1;
        chk("t6_drop_write", 32'(MemWrite), 0);
        chk("t6_drop_ready", 32'(mem_Req_Ready), 0);
        tick();
        Mem_Req_Ready = 1'b1;
        #1;
        chk("t6_idle", 32'(grant_mem), 0);
        chk("t6_no_read", 32'(MemRead), 0);
        chk("t6_no_write", 32'(MemWrite), 0);
        chk("t6_no_ready", 32'(mem_Req_Ready), 0);
        tick();
        chk("t6_stays_idle", 32'(grant_mem | grant_if), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
